// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Single-outstanding instruction fetch unit. The unit samples the external
//   program counter, issues one request to instruction memory, waits for the
//   response and holds the fetched word for decode until it is accepted.
//   On acceptance it pulses pc_write_enable so the external PC register
//   advances. A flush redirects the unit. Any in-flight response is
//   discarded, either immediately or in a DRAIN state. A PC with nonzero low
//   bits is not sent to memory. Decode instead receives a NOP
//   (0x00000013) tagged with inst_misaligned.
//
// Ports:
//   clock            in   1   sole clock, rising edge
//   reset            in   1   synchronous active-high reset
//   pc               in  32   current program counter (fetch address)
//   pc_write_enable  out  1   one-cycle pulse when decode accepts a word
//   flush            in   1   redirect / kill current fetch
//   imem_req_valid   out  1   memory request valid
//   imem_req_ready   in   1   memory accepts request
//   imem_addr        out 32   word-aligned request address
//   imem_rsp_valid   in   1   memory response valid
//   imem_rsp_data    in  32   memory response data
//   inst_valid       out  1   instruction available to decode
//   inst_ready       in   1   decode accepts instruction
//   inst             out 32   fetched instruction
//   inst_pc          out 32   PC of the fetched instruction
//   inst_misaligned  out  1   fetch PC was not word aligned
// ---------------------------------------------------------------------------
module instruction_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_write_enable,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_misaligned
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_misaligned;

  logic        w_pc_aligned;
  logic        w_latch_aligned;    // handshake accepted: remember fetch PC
  logic        w_latch_misaligned; // misaligned PC: remember PC, load NOP
  logic        w_capture_rsp;      // response data becomes the held word
  logic        w_clear_misaligned;

  assign w_pc_aligned = (pc[1:0] == 2'b00);

  // Next-state and handshake outputs; reset dominates every other input.
  always_comb begin
    w_next_state       = r_state;
    imem_req_valid     = 1'b0;
    inst_valid         = 1'b0;
    pc_write_enable    = 1'b0;
    w_latch_aligned    = 1'b0;
    w_latch_misaligned = 1'b0;
    w_capture_rsp      = 1'b0;
    w_clear_misaligned = 1'b0;
    if (reset) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next_state = S_REQ;
        end
        S_REQ: begin
          if (w_pc_aligned) begin
            imem_req_valid = 1'b1;
            if (flush) begin
              // A request already accepted must have its response drained.
              if (imem_req_ready) begin
                w_next_state = S_DRAIN;
              end else begin
                w_next_state = S_REQ;
              end
            end else if (imem_req_ready) begin
              w_latch_aligned = 1'b1;
              w_next_state    = S_WAIT;
            end else begin
              w_next_state = S_REQ;
            end
          end else begin
            if (flush) begin
              w_next_state = S_REQ;
            end else begin
              w_latch_misaligned = 1'b1;
              w_next_state       = S_HOLD;
            end
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (flush) begin
              w_next_state = S_REQ;
            end else begin
              w_capture_rsp = 1'b1;
              w_next_state  = S_HOLD;
            end
          end else if (flush) begin
            w_next_state = S_DRAIN;
          end else begin
            w_next_state = S_WAIT;
          end
        end
        S_HOLD: begin
          inst_valid = 1'b1;
          if (flush) begin
            w_clear_misaligned = 1'b1;
            w_next_state       = S_REQ;
          end else if (inst_ready) begin
            pc_write_enable    = 1'b1;
            w_clear_misaligned = 1'b1;
            w_next_state       = S_REQ;
          end else begin
            w_next_state = S_HOLD;
          end
        end
        S_DRAIN: begin
          // Only the outstanding response releases DRAIN; flush alone does not.
          if (imem_rsp_valid) begin
            w_next_state = S_REQ;
          end else begin
            w_next_state = S_DRAIN;
          end
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // State register and held instruction payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_inst       <= 32'h0000_0000;
      r_inst_pc    <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_latch_aligned) begin
        r_inst_pc    <= pc;
        r_misaligned <= 1'b0;
      end else if (w_latch_misaligned) begin
        r_inst_pc    <= pc;
        r_inst       <= NOP_INST;
        r_misaligned <= 1'b1;
      end else if (w_capture_rsp) begin
        r_inst <= imem_rsp_data;
      end else if (w_clear_misaligned) begin
        r_misaligned <= 1'b0;
      end else begin
        r_misaligned <= r_misaligned;
      end
    end
  end

  // Payload is only presented while holding, so idle/drain outputs read zero.
  assign imem_addr       = imem_req_valid ? {pc[31:2], 2'b00} : 32'h0000_0000;
  assign inst            = inst_valid ? r_inst : 32'h0000_0000;
  assign inst_pc         = inst_valid ? r_inst_pc : 32'h0000_0000;
  assign inst_misaligned = inst_valid ? r_misaligned : 1'b0;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Cycle-by-cycle directed vectors: each record gives the inputs for one
// clock cycle and the outputs expected in that cycle (sampled on the falling
// edge). A main table covers the basic fetch, memory backpressure, decode
// backpressure and misaligned fetch; hand-written sequences then cover flush
// and reset corner cases.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        pc_write_enable;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_misaligned;

  int checks;
  int errors;

  instruction_fetch dut (
    .clock           (clock),
    .reset           (reset),
    .pc              (pc),
    .pc_write_enable (pc_write_enable),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_misaligned (inst_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        fl;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_mis;
    logic        e_pwe;
  } vec_t;

  function automatic vec_t v(
    input logic rst, input logic [31:0] vpc, input logic fl, input logic rdy,
    input logic rv, input logic [31:0] rd, input logic ir,
    input logic e_rqv, input logic [31:0] e_addr, input logic e_iv,
    input logic [31:0] e_inst, input logic [31:0] e_ipc,
    input logic e_mis, input logic e_pwe);
    vec_t r;
    r.rst = rst;  r.pc = vpc;  r.fl = fl;  r.rdy = rdy;
    r.rv = rv;    r.rd = rd;   r.ir = ir;
    r.e_rqv = e_rqv;  r.e_addr = e_addr;  r.e_iv = e_iv;
    r.e_inst = e_inst; r.e_ipc = e_ipc;   r.e_mis = e_mis; r.e_pwe = e_pwe;
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s row %0d: got %08h expected %08h", nm, row, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance to next cycle.
  task automatic apply(input vec_t t, input int row);
    reset          = t.rst;
    pc             = t.pc;
    flush          = t.fl;
    imem_req_ready = t.rdy;
    imem_rsp_valid = t.rv;
    imem_rsp_data  = t.rd;
    inst_ready     = t.ir;
    @(negedge clock);
    chk("imem_req_valid",  row, {31'd0, imem_req_valid},  {31'd0, t.e_rqv});
    chk("imem_addr",       row, imem_addr,                t.e_addr);
    chk("inst_valid",      row, {31'd0, inst_valid},      {31'd0, t.e_iv});
    chk("inst",            row, inst,                     t.e_inst);
    chk("inst_pc",         row, inst_pc,                  t.e_ipc);
    chk("inst_misaligned", row, {31'd0, inst_misaligned}, {31'd0, t.e_mis});
    chk("pc_write_enable", row, {31'd0, pc_write_enable}, {31'd0, t.e_pwe});
    @(posedge clock);
    #1;
  endtask

  vec_t tbl [$];

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; pc = 32'd0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; inst_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    //        rst  pc            fl    rdy   rv    rd            ir    rqv   addr          iv    inst          ipc           mis   pwe
    // reset state, then basic fetch with 1-cycle latency
    tbl.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0050_0093, 32'h0000_0000, 1'b0, 1'b1));
    // memory not ready for 3 cycles at pc=0x100
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    // WAIT: no second request while outstanding, 2-cycle latency
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h00A0_0113, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    // HOLD with decode stalled 5 cycles; stray response ignored
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h00A0_0113, 32'h0000_0100, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h00A0_0113, 32'h0000_0100, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         1'b1, 32'h00A0_0113, 32'h0000_0100, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h00A0_0113, 32'h0000_0100, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h00A0_0113, 32'h0000_0100, 1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h00A0_0113, 32'h0000_0100, 1'b0, 1'b1));
    // misaligned fetch at 0x102: no memory request, NOP delivered
    tbl.push_back(v(1'b0, 32'h0000_0102, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0102, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0013, 32'h0000_0102, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 32'h0000_0102, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0013, 32'h0000_0102, 1'b1, 1'b1));
    tbl.push_back(v(1'b0, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Flush in WAIT, stale response drained two cycles later, refetch at 0x200.
    apply(v(1'b0, 32'h0000_0104, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 100);
    apply(v(1'b0, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 101);
    apply(v(1'b0, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 102);
    apply(v(1'b0, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 103);
    apply(v(1'b0, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 104);
    apply(v(1'b0, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 105);
    apply(v(1'b0, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0033, 32'h0000_0200, 1'b0, 1'b0), 106);

    // Flush with inst_ready in HOLD: no pulse. Then reset (with flush and a
    // response) while WAIT; late response after reset is ignored.
    apply(v(1'b0, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0033, 32'h0000_0200, 1'b0, 1'b0), 200);
    apply(v(1'b0, 32'h0000_0300, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 201);
    apply(v(1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b1, 32'hBAD0_0001, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 202);
    apply(v(1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 203);
    apply(v(1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'hBAD0_0003, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 204);
    apply(v(1'b0, 32'h0000_0300, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 205);
    apply(v(1'b0, 32'h0000_0300, 1'b0, 1'b1, 1'b1, 32'h1357_9BDF, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 206);
    apply(v(1'b0, 32'h0000_0300, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h1357_9BDF, 32'h0000_0300, 1'b0, 1'b1), 207);

    // Flush in REQ without handshake, flush with response in WAIT,
    // flush with handshake in REQ then flush held in DRAIN.
    apply(v(1'b0, 32'h0000_0400, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 300);
    apply(v(1'b0, 32'h0000_0404, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0404, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 301);
    apply(v(1'b0, 32'h0000_0500, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 302);
    apply(v(1'b0, 32'h0000_0500, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 303);
    apply(v(1'b0, 32'h0000_0600, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 304);
    apply(v(1'b0, 32'h0000_0600, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 305);
    apply(v(1'b0, 32'h0000_0600, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0600, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 306);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 clock  in  1  sole clock; all state SHALL update on rising edge.
REQ-002 reset  in  1  SHALL be synchronous, active-high; no asynchronous reset path.
REQ-003 pc  in  32  current program counter value; sampled as fetch address.
REQ-004 pc_write_enable  out  1  single-cycle pulse; PC register loads its next value.
REQ-005 flush  in  1  redirect/kill; PC is rewritten externally in the same cycle.
REQ-006 imem_req_valid  out  1  instruction-memory request valid.
REQ-007 imem_req_ready  in  1  memory accepts request when high with valid.
REQ-008 imem_addr  out  32  request address, {pc[31:2],2'b00}.
REQ-009 imem_rsp_valid  in  1  response data valid; one response per accepted request, latency >=1 cycle.
REQ-010 imem_rsp_data  in  32  instruction word.
REQ-011 inst_valid  out  1  instruction available to decode.
REQ-012 inst_ready  in  1  decode accepts when high with inst_valid.
REQ-013 inst  out  32  fetched instruction (0x00000013 when inst_misaligned).
REQ-014 inst_pc  out  32  PC the instruction was fetched from.
REQ-015 inst_misaligned  out  1  fetch address had pc[1:0]!=0; no memory access made.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DRAIN.
REQ-017 IDLE: all outputs low; next state REQ unconditionally.
REQ-018 REQ, pc[1:0]==0: imem_req_valid=1, imem_addr from pc; on imem_req_ready, latch pc into inst_pc, go WAIT.
REQ-019 REQ, pc[1:0]!=0: imem_req_valid=0; latch pc, set inst_misaligned=1, inst=0x00000013, go HOLD.
REQ-020 imem_addr and imem_req_valid SHALL stay stable while imem_req_valid=1 and imem_req_ready=0, absent flush.
REQ-021 WAIT: on imem_rsp_valid, capture imem_rsp_data into inst, go HOLD; responses in other states SHALL be ignored except in DRAIN.
REQ-022 HOLD: inst_valid=1; inst, inst_pc, inst_misaligned SHALL remain stable until accepted.
REQ-023 HOLD with inst_ready=1 and flush=0: pc_write_enable=1 that cycle, clear inst_misaligned, go REQ.
REQ-024 pc_write_enable SHALL assert only per REQ-023; at most one pulse per delivered instruction.
REQ-025 At most one memory request SHALL be outstanding.
REQ-026 flush in REQ without handshake: drop request, stay REQ (new pc used next cycle).
REQ-027 flush in REQ with handshake same cycle, or in WAIT without imem_rsp_valid: go DRAIN.
REQ-028 flush in WAIT with imem_rsp_valid same cycle: discard data, go REQ.
REQ-029 flush in HOLD: inst_valid deasserts next cycle, no pc_write_enable, go REQ; flush overrides simultaneous inst_ready.
REQ-030 DRAIN: outputs low; on imem_rsp_valid discard data, go REQ; flush in DRAIN stays DRAIN.
REQ-031 flush in IDLE SHALL have no effect.
REQ-032 Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with 1-cycle memory latency.

Reset
REQ-033 reset SHALL force IDLE; imem_req_valid, inst_valid, pc_write_enable, inst_misaligned =0; inst, inst_pc =0.
REQ-034 reset mid-transaction SHALL abandon the outstanding request; a late response SHALL be ignored (arrives in IDLE/REQ).
REQ-035 reset SHALL dominate flush and all handshakes in the same cycle.

Verification
REQ-036 Reset release, pc=0x00000000, ready=1, 1-cycle latency, rsp 0x00500093 -> req at 0x0 in cycle 2; inst_valid cycle 4, inst=0x00500093, inst_pc=0; pc_write_enable on accept.
REQ-037 imem_req_ready low 3 cycles, pc=0x100 -> imem_req_valid held, imem_addr=0x100 stable; single request issued.
REQ-038 HOLD, inst_ready low 5 cycles -> inst/inst_pc stable, no pc_write_enable; pulse exactly once when inst_ready rises.
REQ-039 flush in WAIT, pc rewritten to 0x200, stale rsp 0xDEADBEEF 2 cycles later -> DRAIN discards; next req addr 0x200; 0xDEADBEEF never on inst.
REQ-040 pc=0x102 -> no imem_req_valid; inst_valid with inst_misaligned=1, inst_pc=0x102, inst=0x00000013.
REQ-041 flush with inst_ready in HOLD; then reset in WAIT -> no pc_write_enable; after reset all outputs 0, late rsp ignored.
